// File: rtl/pht_branch_predictor_pkg.sv
// Shared constants and helpers for the pattern-history-table branch predictor.
package pht_branch_predictor_pkg;

  // Major opcode of RV conditional branches (B-type).
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Width of the raw B-type immediate, including the implicit zero LSB.
  localparam int unsigned B_IMM_BITS = 13;

  // Widest supported counter; narrower counters are zero-extended into this.
  localparam int unsigned MAX_CTR_BITS = 4;

  // Saturating up/down step of a ctrBits-wide unsigned counter.
  function automatic logic [MAX_CTR_BITS-1:0] ctrNext(
    input logic [MAX_CTR_BITS-1:0] ctr,
    input logic                    taken,
    input int unsigned             ctrBits
  );
    logic [MAX_CTR_BITS-1:0] ctrMax;
    ctrMax = MAX_CTR_BITS'((1 << ctrBits) - 1);
    if (taken) begin
      ctrNext = (ctr == ctrMax) ? ctr : ctr + 4'd1;
    end else begin
      ctrNext = (ctr == '0) ? ctr : ctr - 4'd1;
    end
  endfunction

endpackage

// File: rtl/pht_branch_predictor_b_imm_decode.sv
// Extracts and sign-extends the B-type branch offset from an instruction word.
module b_imm_decode
  import pht_branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic [B_IMM_BITS-1:0] raw;
  logic                  unusedBits;

  // Reassemble the scattered immediate fields; the offset is already in bytes.
  always_comb begin
    raw        = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm        = {{(XLEN - B_IMM_BITS){raw[B_IMM_BITS-1]}}, raw};
    unusedBits = ^{instr[24:12], instr[6:0]};
  end

endmodule

// File: rtl/pht_branch_predictor.sv
// Fetch-stage conditional-branch predictor: PC- or gshare-indexed PHT of
// saturating counters, next-PC selection and late-misprediction redirect.
module pht_branch_predictor
  import pht_branch_predictor_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     PHT_ENTRIES = 64,
  parameter int unsigned     CTR_BITS    = 2,
  parameter int unsigned     HIST_BITS   = 6,
  parameter int unsigned     MODE        = 0,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  localparam int unsigned    IDX         = $clog2(PHT_ENTRIES)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [31:0]     fetch_instr,
  output logic [XLEN-1:0] next_pc,
  output logic            predict_taken,
  output logic [IDX-1:0]  predict_index,
  input  logic            resolve_valid,
  input  logic [XLEN-1:0] resolve_pc,
  input  logic [IDX-1:0]  resolve_index,
  input  logic            resolve_taken,
  input  logic            resolve_predicted,
  input  logic [XLEN-1:0] resolve_target,
  output logic            flush,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0]  pht [PHT_ENTRIES];
  logic [HIST_BITS-1:0] ghr;
  logic [XLEN-1:0]      bImm;
  logic [XLEN-1:0]      takenTarget;
  logic [IDX-1:0]       pcIdx;
  logic                 isBranch;
  logic                 mispredict;

  b_imm_decode #(.XLEN(XLEN)) uBImmDecode (
    .instr (fetch_instr),
    .imm   (bImm)
  );

  // Table index, branch detection and candidate targets for the fetched word.
  always_comb begin
    pcIdx         = fetch_pc[IDX+1:2];
    predict_index = (MODE == 1) ? (pcIdx ^ IDX'(ghr)) : pcIdx;
    isBranch      = fetch_valid && (fetch_instr[6:0] == OP_BRANCH);
    mispredict    = resolve_valid && (resolve_taken != resolve_predicted);
    takenTarget   = fetch_pc + bImm;
  end

  // Next-PC priority: reset, then late redirect, then predicted-taken, else fall-through.
  always_comb begin
    next_pc       = fetch_pc + XLEN'(4);
    predict_taken = 1'b0;
    flush         = 1'b0;
    if (reset) begin
      next_pc = RESET_PC;
    end else begin
      predict_taken = isBranch && pht[predict_index][CTR_BITS-1];
      if (mispredict) begin
        flush   = 1'b1;
        next_pc = resolve_taken ? resolve_target : resolve_pc + XLEN'(4);
      end else if (predict_taken) begin
        next_pc = takenTarget;
      end
    end
  end

  // Train counters and history from resolved branches; counts saturate instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < PHT_ENTRIES; i++) begin
        pht[IDX'(i)] <= CTR_WEAK_NT;
      end
      ghr              <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (resolve_valid) begin
      pht[resolve_index] <= CTR_BITS'(ctrNext(MAX_CTR_BITS'(pht[resolve_index]),
                                              resolve_taken, CTR_BITS));
      // Truncating {ghr, taken} drops the oldest bit and also covers HIST_BITS == 1.
      ghr <= HIST_BITS'({ghr, resolve_taken});
      if (branch_count != '1) begin
        branch_count <= branch_count + 32'd1;
      end
      if (mispredict && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pht_branch_predictor.sv
// Scoreboard bench for pht_branch_predictor: three configurations share one stimulus stream.
module tb_pht_branch_predictor;

  logic        clock;
  logic        reset;
  logic        fetchValid;
  logic [63:0] fetchPc;
  logic [31:0] fetchInstr;
  logic        resolveValid;
  logic [63:0] resolvePc;
  logic [5:0]  resolveIndex;
  logic        resolveTaken;
  logic        resolvePredicted;
  logic [63:0] resolveTarget;

  logic [63:0] aNextPc, bNextPc, cNextPc;
  logic        aTaken, bTaken, cTaken;
  logic [5:0]  aIndex, bIndex, cIndex;
  logic        aFlush, bFlush, cFlush;
  logic [31:0] aBr, bBr, cBr, aMis, bMis, cMis;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          nChecks = 0;
  int          nFail = 0;
  int          brModel = 0;
  int          misModel = 0;
  int          mPht[64];
  logic [1:0]  mGhr;

  pht_branch_predictor #(.RESET_PC(64'h1000)) dutA (
    .clock(clock), .reset(reset), .fetch_valid(fetchValid), .fetch_pc(fetchPc),
    .fetch_instr(fetchInstr), .next_pc(aNextPc), .predict_taken(aTaken), .predict_index(aIndex),
    .resolve_valid(resolveValid), .resolve_pc(resolvePc), .resolve_index(resolveIndex),
    .resolve_taken(resolveTaken), .resolve_predicted(resolvePredicted),
    .resolve_target(resolveTarget), .flush(aFlush), .branch_count(aBr), .mispredict_count(aMis)
  );

  pht_branch_predictor #(.CTR_BITS(3)) dutB (
    .clock(clock), .reset(reset), .fetch_valid(fetchValid), .fetch_pc(fetchPc),
    .fetch_instr(fetchInstr), .next_pc(bNextPc), .predict_taken(bTaken), .predict_index(bIndex),
    .resolve_valid(resolveValid), .resolve_pc(resolvePc), .resolve_index(resolveIndex),
    .resolve_taken(resolveTaken), .resolve_predicted(resolvePredicted),
    .resolve_target(resolveTarget), .flush(bFlush), .branch_count(bBr), .mispredict_count(bMis)
  );

  pht_branch_predictor #(.MODE(1), .HIST_BITS(2)) dutC (
    .clock(clock), .reset(reset), .fetch_valid(fetchValid), .fetch_pc(fetchPc),
    .fetch_instr(fetchInstr), .next_pc(cNextPc), .predict_taken(cTaken), .predict_index(cIndex),
    .resolve_valid(resolveValid), .resolve_pc(resolvePc), .resolve_index(resolveIndex),
    .resolve_taken(resolveTaken), .resolve_predicted(resolvePredicted),
    .resolve_target(resolveTarget), .flush(cFlush), .branch_count(cBr), .mispredict_count(cMis)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] encBranch(input int imm);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'd0, 5'd0, 3'b000, v[4:1], v[11], 7'b1100011};
  endfunction

  task automatic push(input string n, input logic [63:0] v);
    exp_t t;
    t.name = n;
    t.exp  = v;
    sb.push_back(t);
  endtask

  task automatic idle();
    fetchValid   = 1'b0;
    fetchInstr   = '0;
    resolveValid = 1'b0;
  endtask

  task automatic setFetch(input logic [63:0] pc, input logic [31:0] instr);
    fetchValid = 1'b1;
    fetchPc    = pc;
    fetchInstr = instr;
  endtask

  task automatic driveResolve(input logic [63:0] pc, input logic [5:0] idx, input logic taken,
                              input logic pred, input logic [63:0] target);
    resolveValid     = 1'b1;
    resolvePc        = pc;
    resolveIndex     = idx;
    resolveTaken     = taken;
    resolvePredicted = pred;
    resolveTarget    = target;
    if (!reset) begin
      brModel++;
      if (taken != pred) misModel++;
    end
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    idle();
    @(negedge clock);
    reset    = 1'b0;
    brModel  = 0;
    misModel = 0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    setFetch(64'h100, encBranch(16));
    driveResolve(64'h300, 6'd0, 1'b0, 1'b1, 64'h400);
    push("reset next_pc", 64'h1000);
    push("reset predict_taken", 64'd0);
    push("reset flush", 64'd0);
    #1;
    e = sb.pop_front(); nChecks++;
    if (aNextPc !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aNextPc, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aTaken, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aFlush !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aFlush, e.exp); end
    @(negedge clock);
    idle();
    @(negedge clock);
    reset    = 1'b0;
    brModel  = 0;
    misModel = 0;
    push("reset branch_count", 64'(brModel));
    push("reset mispredict_count", 64'(misModel));
    #1;
    e = sb.pop_front(); nChecks++;
    if (aBr !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aBr, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aMis !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aMis, e.exp); end
  endtask

  task automatic test_predict();
    @(negedge clock);
    idle();
    setFetch(64'h100, encBranch(16));
    push("cold predict_taken", 64'd0);
    push("cold next_pc", 64'h104);
    push("cold predict_index", 64'd0);
    #1;
    e = sb.pop_front(); nChecks++;
    if (aTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aTaken, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aNextPc !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aNextPc, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aIndex !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aIndex, e.exp); end
  endtask

  task automatic test_train();
    // Update and read of index 0 in the same cycle: prediction sees 01.
    @(negedge clock);
    idle();
    setFetch(64'h100, encBranch(16));
    driveResolve(64'h100, 6'd0, 1'b1, 1'b1, 64'h110);
    push("same-cycle predict_taken", 64'd0);
    push("same-cycle next_pc", 64'h104);
    #1;
    e = sb.pop_front(); nChecks++;
    if (aTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aTaken, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aNextPc !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aNextPc, e.exp); end
    @(negedge clock);
    idle();
    setFetch(64'h100, encBranch(16));
    driveResolve(64'h100, 6'd0, 1'b1, 1'b1, 64'h110);
    push("trained predict_taken", 64'd1);
    push("trained next_pc", 64'h110);
    #1;
    e = sb.pop_front(); nChecks++;
    if (aTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aTaken, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aNextPc !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aNextPc, e.exp); end
    @(negedge clock);
    idle();
    driveResolve(64'h100, 6'd0, 1'b1, 1'b1, 64'h110);
    @(negedge clock);
    idle();
    driveResolve(64'h100, 6'd0, 1'b0, 1'b0, 64'h110);
    @(negedge clock);
    idle();
    setFetch(64'h100, encBranch(16));
    push("held-at-max predict_taken", 64'd1);
    push("held-at-max next_pc", 64'h110);
    push("train branch_count", 64'(brModel));
    push("train mispredict_count", 64'(misModel));
    #1;
    e = sb.pop_front(); nChecks++;
    if (aTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aTaken, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aNextPc !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aNextPc, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aBr !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aBr, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aMis !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aMis, e.exp); end
  endtask

  task automatic test_mispredict();
    @(negedge clock);
    idle();
    setFetch(64'h100, encBranch(16));
    driveResolve(64'h100, 6'd0, 1'b0, 1'b1, 64'h110);
    push("mispredict NT flush", 64'd1);
    push("mispredict NT next_pc", 64'h104);
    #1;
    e = sb.pop_front(); nChecks++;
    if (aFlush !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aFlush, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aNextPc !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aNextPc, e.exp); end
    @(negedge clock);
    idle();
    setFetch(64'h100, encBranch(16));
    push("after NT predict_taken", 64'd0);
    push("after NT mispredict_count", 64'(misModel));
    push("after NT branch_count", 64'(brModel));
    #1;
    e = sb.pop_front(); nChecks++;
    if (aTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aTaken, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aMis !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aMis, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aBr !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aBr, e.exp); end
    driveResolve(64'h100, 6'd0, 1'b1, 1'b0, 64'h2000);
    push("mispredict T flush", 64'd1);
    push("mispredict T next_pc", 64'h2000);
    #1;
    e = sb.pop_front(); nChecks++;
    if (aFlush !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aFlush, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aNextPc !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aNextPc, e.exp); end
    @(negedge clock);
    idle();
    setFetch(64'h100, encBranch(16));
    push("after T predict_taken", 64'd1);
    push("after T mispredict_count", 64'(misModel));
    #1;
    e = sb.pop_front(); nChecks++;
    if (aTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aTaken, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aMis !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aMis, e.exp); end
  endtask

  task automatic test_fetch_gating();
    logic [63:0] pc;
    @(negedge clock);
    idle();
    fetchPc    = 64'h100;
    fetchInstr = encBranch(16);
    push("invalid fetch predict_taken", 64'd0);
    push("invalid fetch next_pc", 64'h104);
    push("invalid fetch flush", 64'd0);
    #1;
    e = sb.pop_front(); nChecks++;
    if (aTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aTaken, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aNextPc !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aNextPc, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aFlush !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aFlush, e.exp); end
    setFetch(64'h100, 32'h0000_0013);
    push("non-branch predict_taken", 64'd0);
    #1;
    e = sb.pop_front(); nChecks++;
    if (aTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aTaken, e.exp); end
    setFetch(64'h100, encBranch(-512));
    push("backward wrap next_pc", 64'hFFFF_FFFF_FFFF_FF00);
    #1;
    e = sb.pop_front(); nChecks++;
    if (aNextPc !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aNextPc, e.exp); end
    pc = 64'h1234_5678;
    setFetch(pc, encBranch(16));
    push("pc index", (pc >> 2) & 64'h3F);
    push("untrained index next_pc", pc + 64'd4);
    #1;
    e = sb.pop_front(); nChecks++;
    if (aIndex !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aIndex, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aNextPc !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aNextPc, e.exp); end
    fetchValid = 1'b0;
    driveResolve(64'h100, 6'd0, 1'b1, 1'b0, 64'h2000);
    push("invalid fetch redirect next_pc", 64'h2000);
    push("invalid fetch redirect flush", 64'd1);
    #1;
    e = sb.pop_front(); nChecks++;
    if (aNextPc !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aNextPc, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aFlush !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aFlush, e.exp); end
  endtask

  task automatic test_saturation();
    doReset();
    @(negedge clock);
    idle();
    driveResolve(64'h14, 6'd5, 1'b1, 1'b1, 64'h24);
    @(negedge clock);
    idle();
    setFetch(64'h14, encBranch(16));
    push("3-bit weak+1 predict_taken", 64'd1);
    #1;
    e = sb.pop_front(); nChecks++;
    if (bTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, bTaken, e.exp); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      idle();
      driveResolve(64'h14, 6'd5, 1'b0, 1'b0, 64'h24);
    end
    @(negedge clock);
    idle();
    driveResolve(64'h14, 6'd5, 1'b1, 1'b1, 64'h24);
    @(negedge clock);
    idle();
    setFetch(64'h14, encBranch(16));
    push("3-bit floor+1 predict_taken", 64'd0);
    push("3-bit floor+1 next_pc", 64'h18);
    #1;
    e = sb.pop_front(); nChecks++;
    if (bTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, bTaken, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (bNextPc !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, bNextPc, e.exp); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      idle();
      driveResolve(64'h14, 6'd5, 1'b1, 1'b1, 64'h24);
    end
    @(negedge clock);
    idle();
    setFetch(64'h14, encBranch(16));
    push("3-bit count 3 predict_taken", 64'd0);
    #1;
    e = sb.pop_front(); nChecks++;
    if (bTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, bTaken, e.exp); end
    @(negedge clock);
    idle();
    driveResolve(64'h14, 6'd5, 1'b1, 1'b1, 64'h24);
    @(negedge clock);
    idle();
    setFetch(64'h14, encBranch(16));
    push("3-bit count 4 predict_taken", 64'd1);
    push("3-bit count 4 next_pc", 64'h24);
    #1;
    e = sb.pop_front(); nChecks++;
    if (bTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, bTaken, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (bNextPc !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, bNextPc, e.exp); end
  endtask

  task automatic test_gshare();
    logic       outcome;
    logic       expT;
    logic [1:0] idx;
    doReset();
    foreach (mPht[k]) mPht[k] = 1;
    mGhr = '0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      idle();
      outcome = (i % 2 == 0);
      idx     = mGhr;
      expT    = (mPht[idx] >= 2);
      setFetch(64'h200, encBranch(16));
      driveResolve(64'h200, 6'(idx), outcome, expT, 64'h210);
      push("gshare predict_index", 64'(idx));
      push("gshare predict_taken", 64'(expT));
      push("gshare flush", 64'(outcome != expT));
      // A wrong guess redirects to the actual path, a right one already follows it.
      push("gshare next_pc", outcome ? 64'h210 : 64'h204);
      #1;
      e = sb.pop_front(); nChecks++;
      if (cIndex !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, cIndex, e.exp); end
      e = sb.pop_front(); nChecks++;
      if (cTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, cTaken, e.exp); end
      e = sb.pop_front(); nChecks++;
      if (cFlush !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, cFlush, e.exp); end
      e = sb.pop_front(); nChecks++;
      if (cNextPc !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, cNextPc, e.exp); end
      if (i >= 6) begin
        push("gshare warmed exact", 64'(outcome));
        e = sb.pop_front(); nChecks++;
        if (cTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, cTaken, e.exp); end
      end
      if (outcome) mPht[idx] = (mPht[idx] == 3) ? 3 : mPht[idx] + 1;
      else mPht[idx] = (mPht[idx] == 0) ? 0 : mPht[idx] - 1;
      mGhr = {mGhr[0], outcome};
    end
    @(negedge clock);
    idle();
    push("gshare mispredict_count", 64'(misModel));
    push("gshare branch_count", 64'd24);
    #1;
    e = sb.pop_front(); nChecks++;
    if (cMis !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, cMis, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (cBr !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, cBr, e.exp); end
  endtask

  task automatic test_reset_mid();
    doReset();
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clock);
        idle();
        driveResolve(64'(i) << 2, 6'(i), 1'b1, 1'b1, 64'h0);
      end
    end
    @(negedge clock);
    idle();
    setFetch(64'h0, encBranch(16));
    push("saturated predict_taken", 64'd1);
    push("saturated branch_count", 64'(brModel));
    #1;
    e = sb.pop_front(); nChecks++;
    if (aTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aTaken, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aBr !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aBr, e.exp); end
    @(negedge clock);
    idle();
    reset = 1'b1;
    setFetch(64'h100, encBranch(16));
    driveResolve(64'h100, 6'd0, 1'b0, 1'b1, 64'h500);
    push("mid reset next_pc", 64'h1000);
    push("mid reset predict_taken", 64'd0);
    push("mid reset flush", 64'd0);
    #1;
    e = sb.pop_front(); nChecks++;
    if (aNextPc !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aNextPc, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aTaken !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aTaken, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aFlush !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aFlush, e.exp); end
    @(negedge clock);
    idle();
    reset    = 1'b0;
    brModel  = 0;
    misModel = 0;
    push("mid reset branch_count", 64'(brModel));
    push("mid reset mispredict_count", 64'(misModel));
    #1;
    e = sb.pop_front(); nChecks++;
    if (aBr !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aBr, e.exp); end
    e = sb.pop_front(); nChecks++;
    if (aMis !== e.exp) begin nFail++; $display("FAIL %s: got %0h expected %0h", e.name, aMis, e.exp); end
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      idle();
      setFetch(64'(i) << 2, encBranch(16));
      push("post-reset weak predict_taken", 64'd0);
      #1;
      e = sb.pop_front(); nChecks++;
      if (aTaken !== e.exp) begin nFail++; $display("FAIL %s[%0d]: got %0h expected %0h", e.name, i, aTaken, e.exp); end
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      idle();
      driveResolve(64'(i) << 2, 6'(i), 1'b1, 1'b1, 64'h0);
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      idle();
      setFetch(64'(i) << 2, encBranch(16));
      push("post-reset one-taken predict_taken", 64'd1);
      #1;
      e = sb.pop_front(); nChecks++;
      if (aTaken !== e.exp) begin nFail++; $display("FAIL %s[%0d]: got %0h expected %0h", e.name, i, aTaken, e.exp); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    fetchPc          = '0;
    resolvePc        = '0;
    resolveIndex     = '0;
    resolveTaken     = 1'b0;
    resolvePredicted = 1'b0;
    resolveTarget    = '0;
    idle();
    test_reset();
    test_predict();
    test_train();
    test_mispredict();
    test_fetch_gating();
    test_saturation();
    test_gshare();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
